demux4_feeder: RTL and testbench

- Upstream stage for the 1-to-4 demux (demux4to1).
- Accepts {data bit, destination select} pairs over a valid/ready handshake and buffers them in a small FIFO.
- Presents each pair on the demux's din/sel inputs for a fixed number of cycles.
- Ensures the demux only sees stable, paced select changes.

---
 rtl/demux4_pkg.sv | 17 +
 rtl/demux4_fifo.sv | 65 ++++++
 rtl/demux4_feeder.sv | 142 ++++++++++++++
 tb/tb_demux4_feeder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared types for the demux4 feeder: the buffered {din, sel} entry and the
// presentation FSM state encoding.
package demux4_pkg;

  localparam int SEL_W = 2;

  typedef struct packed {
    logic             din;
    logic [SEL_W-1:0] sel;
  } demux_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/demux4_fifo.sv
// Synchronous show-ahead FIFO of demux entries. Pointers wrap naturally, and
// the full/empty flags come from the occupancy counter.
module demux4_fifo
  import demux4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  demux_entry_t                 wdata,
  output demux_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  demux_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/demux4_feeder.sv
// Paces buffered {din, sel} entries onto the 1-to-4 demux, holding each for HOLD cycles.
//   state | meaning
//   IDLE  | nothing presented; din=0, sel=IDLE_SEL
//   HOLD  | an entry is on din/sel; hold_cnt counts the remaining cycles
module demux4_feeder
  import demux4_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               HOLD     = 2,
  parameter logic [SEL_W-1:0] IDLE_SEL = 2'b00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_din,
  input  logic [SEL_W-1:0]             in_sel,
  output logic                         din,
  output logic [SEL_W-1:0]             sel,
  output logic                         out_active,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int              HCW         = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_RELOAD = HCW'(HOLD - 1);

  feeder_state_t    state_q, state_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             din_q, din_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             active_q, active_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  demux_entry_t     fifo_head;
  demux_entry_t     fifo_wdata;
  logic             hold_done;

  // in_ready looks only at the registered count, so a pop in a full cycle cannot open a slot.
  assign in_ready   = rst_n && !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_wdata = '{din: in_din, sel: in_sel};
  assign hold_done  = (hold_cnt_q == '0);

  demux4_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      din_q      <= 1'b0;
      sel_q      <= IDLE_SEL;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      din_q      <= din_d;
      sel_q      <= sel_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = demux4_pkg::HOLD;
        end
      end
      demux4_pkg::HOLD: begin
        if (hold_done && fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop   = 1'b0;
    hold_cnt_d = hold_cnt_q;
    din_d      = din_q;
    sel_d      = sel_q;
    active_d   = active_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          din_d      = fifo_head.din;
          sel_d      = fifo_head.sel;
          active_d   = 1'b1;
          hold_cnt_d = HOLD_RELOAD;
        end
      end
      demux4_pkg::HOLD: begin
        if (!hold_done) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else if (!fifo_empty) begin
          // Back-to-back: the next entry replaces the current one at the same edge.
          fifo_pop   = 1'b1;
          din_d      = fifo_head.din;
          sel_d      = fifo_head.sel;
          active_d   = 1'b1;
          hold_cnt_d = HOLD_RELOAD;
        end else begin
          din_d      = 1'b0;
          sel_d      = IDLE_SEL;
          active_d   = 1'b0;
        end
      end
      default: begin
        din_d      = 1'b0;
        sel_d      = IDLE_SEL;
        active_d   = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  assign din        = din_q;
  assign sel        = sel_q;
  assign out_active = active_q;

  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == demux4_pkg::HOLD && !hold_done) |=> $stable(sel_q));

endmodule

// File: tb/tb_demux4_feeder.sv
// Directed bench for demux4_feeder: three instances cover HOLD=2, HOLD=3 and HOLD=1.
module tb_demux4_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: HOLD=2
  logic       rst_a, valid_a, ready_a, in_din_a, din_a, act_a;
  logic [1:0] in_sel_a, sel_a;
  logic [2:0] count_a;
  // Instance B: HOLD=3
  logic       rst_b, valid_b, ready_b, in_din_b, din_b, act_b;
  logic [1:0] in_sel_b, sel_b;
  logic [2:0] count_b;
  // Instance C: HOLD=1
  logic       rst_c, valid_c, ready_c, in_din_c, din_c, act_c;
  logic [1:0] in_sel_c, sel_c;
  logic [2:0] count_c;

  demux4_feeder #(.DEPTH(4), .HOLD(2), .IDLE_SEL(2'b00)) u_a (
    .clk(clk), .rst_n(rst_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_din(in_din_a), .in_sel(in_sel_a), .din(din_a), .sel(sel_a),
    .out_active(act_a), .count(count_a)
  );
  demux4_feeder #(.DEPTH(4), .HOLD(3), .IDLE_SEL(2'b00)) u_b (
    .clk(clk), .rst_n(rst_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_din(in_din_b), .in_sel(in_sel_b), .din(din_b), .sel(sel_b),
    .out_active(act_b), .count(count_b)
  );
  demux4_feeder #(.DEPTH(4), .HOLD(1), .IDLE_SEL(2'b00)) u_c (
    .clk(clk), .rst_n(rst_c), .in_valid(valid_c), .in_ready(ready_c),
    .in_din(in_din_c), .in_sel(in_sel_c), .din(din_c), .sel(sel_c),
    .out_active(act_c), .count(count_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Burst table for B: entry payloads and per-edge count/in_ready expectations.
  logic       b_din [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] b_sel [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [2:0] b_cnt [9] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4};
  logic       b_rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] m_sel [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int o;
    logic       s_din;
    logic [1:0] s_sel;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    in_din_a = 1'b0; in_din_b = 1'b0; in_din_c = 1'b0;
    in_sel_a = 2'd0; in_sel_b = 2'd0; in_sel_c = 2'd0;

    // Reset held for two edges, then released with no input.
    step();
    chk("rst_ready_low_1", 8'(ready_a), 8'd0);
    step();
    chk("rst_ready_low_2", 8'(ready_a), 8'd0);
    chk("rst_din",   8'(din_a),   8'd0);
    chk("rst_sel",   8'(sel_a),   8'd0);
    chk("rst_act",   8'(act_a),   8'd0);
    chk("rst_count", 8'(count_a), 8'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    step();
    chk("idle_ready",   8'(ready_a), 8'd1);
    chk("idle_din",     8'(din_a),   8'd0);
    chk("idle_sel",     8'(sel_a),   8'd0);
    chk("idle_act",     8'(act_a),   8'd0);
    chk("idle_count",   8'(count_a), 8'd0);
    chk("idle_ready_b", 8'(ready_b), 8'd1);
    chk("idle_ready_c", 8'(ready_c), 8'd1);

    // Single entry on A: pushed at edge k, shown after k+1 and k+2, idle after k+3.
    valid_a = 1'b1; in_din_a = 1'b1; in_sel_a = 2'b10;
    step();
    valid_a = 1'b0;
    chk("single_k_count", 8'(count_a), 8'd1);
    chk("single_k_act",   8'(act_a),   8'd0);
    step();
    chk("single_k1_din",   8'(din_a),   8'd1);
    chk("single_k1_sel",   8'(sel_a),   8'd2);
    chk("single_k1_act",   8'(act_a),   8'd1);
    chk("single_k1_count", 8'(count_a), 8'd0);
    step();
    chk("single_k2_din", 8'(din_a), 8'd1);
    chk("single_k2_sel", 8'(sel_a), 8'd2);
    chk("single_k2_act", 8'(act_a), 8'd1);
    step();
    chk("single_k3_din", 8'(din_a), 8'd0);
    chk("single_k3_sel", 8'(sel_a), 8'd0);
    chk("single_k3_act", 8'(act_a), 8'd0);

    // Reset mid-hold on A: five pushes leave entry 1 presented and three buffered.
    for (int i = 0; i < 5; i++) begin
      valid_a = 1'b1; in_din_a = 1'b1; in_sel_a = m_sel[i];
      step();
    end
    valid_a = 1'b0;
    chk("midhold_pre_count", 8'(count_a), 8'd3);
    chk("midhold_pre_act",   8'(act_a),   8'd1);
    chk("midhold_pre_sel",   8'(sel_a),   8'd2);
    rst_a = 1'b0;
    step();
    chk("midhold_rst_din",   8'(din_a),   8'd0);
    chk("midhold_rst_sel",   8'(sel_a),   8'd0);
    chk("midhold_rst_act",   8'(act_a),   8'd0);
    chk("midhold_rst_count", 8'(count_a), 8'd0);
    chk("midhold_rst_ready", 8'(ready_a), 8'd0);
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("midhold_after_act_%0d", i),   8'(act_a),   8'd0);
      chk($sformatf("midhold_after_count_%0d", i), 8'(count_a), 8'd0);
    end

    // Burst fill on B (HOLD=3): seven entries, fills at edge 6, full+pop at edge 8.
    for (int e = 1; e <= 23; e++) begin
      if (e <= 9) begin
        idx = (e <= 6) ? e - 1 : 6;
        valid_b = 1'b1; in_din_b = b_din[idx]; in_sel_b = b_sel[idx];
      end else begin
        valid_b = 1'b0;
      end
      step();
      if (e <= 9) begin
        chk($sformatf("burst_count_e%0d", e), 8'(count_b), 8'(b_cnt[e-1]));
        chk($sformatf("burst_ready_e%0d", e), 8'(ready_b), 8'(b_rdy[e-1]));
      end
      if (e >= 2 && e <= 22) begin
        o = (e - 2) / 3;
        chk($sformatf("burst_act_e%0d", e), 8'(act_b), 8'd1);
        chk($sformatf("burst_sel_e%0d", e), 8'(sel_b), 8'(b_sel[o]));
        chk($sformatf("burst_din_e%0d", e), 8'(din_b), 8'(b_din[o]));
      end else begin
        chk($sformatf("burst_idle_act_e%0d", e), 8'(act_b), 8'd0);
        chk($sformatf("burst_idle_sel_e%0d", e), 8'(sel_b), 8'd0);
      end
    end

    // HOLD=1 streaming on C: one new entry on the outputs every cycle.
    for (int e = 1; e <= 10; e++) begin
      if (e <= 8) begin
        valid_c = 1'b1;
        in_din_c = ((e - 1) % 2 == 0) ? 1'b1 : 1'b0;
        in_sel_c = 2'(3 - ((e - 1) % 4));
      end else begin
        valid_c = 1'b0;
      end
      step();
      chk($sformatf("stream_ready_e%0d", e), 8'(ready_c), 8'd1);
      chk($sformatf("stream_count_e%0d", e), 8'(count_c), (e <= 8) ? 8'd1 : 8'd0);
      if (e >= 2 && e <= 9) begin
        s_din = ((e - 2) % 2 == 0) ? 1'b1 : 1'b0;
        s_sel = 2'(3 - ((e - 2) % 4));
        chk($sformatf("stream_act_e%0d", e), 8'(act_c), 8'd1);
        chk($sformatf("stream_din_e%0d", e), 8'(din_c), 8'(s_din));
        chk($sformatf("stream_sel_e%0d", e), 8'(sel_c), 8'(s_sel));
      end else begin
        chk($sformatf("stream_idle_act_e%0d", e), 8'(act_c), 8'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
